bavul_tahsilat: RTL

//  Collection end of the baggage-fee path: takes the fee issued by the bagaj fee calculator (ucret + bitti pulse),

---
 rtl/bavul_tahsilat_pkg.sv | 20 ++
 rtl/bavul_tahsilat_para_cozucu.sv | 20 ++
 rtl/bavul_tahsilat.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bavul_tahsilat_pkg.sv
// Shared types and constants for the baggage-fee collection block.
// Coin codes map to fixed unit values; the FSM has four states.
package bavul_tahsilat_pkg;

    typedef enum logic [1:0] {
        StBekle    = 2'd0,
        StTahsilat = 2'd1,
        StOnay     = 2'd2,
        StIade     = 2'd3
    } durum_t;

    localparam int unsigned ParaW = 9;
    localparam int unsigned KasaW = 16;

    localparam logic [ParaW-1:0] ParaDeger0 = 9'd1;
    localparam logic [ParaW-1:0] ParaDeger1 = 9'd5;
    localparam logic [ParaW-1:0] ParaDeger2 = 9'd10;
    localparam logic [ParaW-1:0] ParaDeger3 = 9'd20;

endpackage

// File: rtl/bavul_tahsilat_para_cozucu.sv
// Coin decoder: 2-bit coin code to its 9-bit unit value.
module bavul_tahsilat_para_cozucu
    import bavul_tahsilat_pkg::*;
(
    input  logic [1:0]       i_para,
    output logic [ParaW-1:0] o_deger
);

    always_comb begin
        o_deger = ParaDeger0;
        unique case (i_para)
            2'd0:    o_deger = ParaDeger0;
            2'd1:    o_deger = ParaDeger1;
            2'd2:    o_deger = ParaDeger2;
            2'd3:    o_deger = ParaDeger3;
            default: o_deger = ParaDeger0;
        endcase
    end

endmodule

// File: rtl/bavul_tahsilat.sv
// Baggage-fee collection: accepts a fee, gathers coins, confirms or refunds,
// and tracks paid passengers and the till total. All outputs are registered.
module bavul_tahsilat
    import bavul_tahsilat_pkg::*;
#(
    parameter int unsigned ZAMAN_ASIMI = 1000,
    parameter int unsigned MAKS_YOLCU  = 50
) (
    input  logic             i_saat,
    input  logic             i_reset,
    input  logic [7:0]       i_ucret,
    input  logic             i_ucret_gecerli,
    input  logic [1:0]       i_para,
    input  logic             i_para_gecerli,
    input  logic             i_iptal,
    output logic             o_hazir,
    output logic             o_odendi,
    output logic             o_iade,
    output logic [ParaW-1:0] o_para_ustu,
    output logic [ParaW-1:0] o_odenen,
    output logic [5:0]       o_yolcu_sayisi,
    output logic             o_ucak_dolu,
    output logic [KasaW-1:0] o_kasa
);

    localparam int unsigned ZW = (ZAMAN_ASIMI > 1) ? $clog2(ZAMAN_ASIMI) : 1;

    durum_t             r_durum, w_durum_d;
    logic [7:0]         r_ucret, w_ucret_d;
    logic [ParaW-1:0]   r_odenen, w_odenen_d;
    logic [ZW-1:0]      r_zaman, w_zaman_d;
    logic [ParaW-1:0]   r_para_ustu, w_para_ustu_d;
    logic               r_odendi, w_odendi_d;
    logic               r_iade, w_iade_d;
    logic               r_hazir, w_hazir_d;
    logic [5:0]         r_yolcu, w_yolcu_d;
    logic               r_dolu, w_dolu_d;
    logic [KasaW-1:0]   r_kasa, w_kasa_d;

    logic [ParaW-1:0]   w_para_deger;
    logic [ParaW-1:0]   w_odenen_n;
    logic [KasaW:0]     w_kasa_top;
    logic [KasaW-1:0]   w_kasa_doygun;
    logic [5:0]         w_yolcu_art;
    logic               w_zaman_doldu;

    bavul_tahsilat_para_cozucu u_para_cozucu (
        .i_para  (i_para),
        .o_deger (w_para_deger)
    );

    assign w_odenen_n    = i_para_gecerli ? (r_odenen + w_para_deger) : r_odenen;
    assign w_kasa_top    = {1'b0, r_kasa} + {{(KasaW - 7){1'b0}}, r_ucret};
    assign w_kasa_doygun = w_kasa_top[KasaW] ? {KasaW{1'b1}} : w_kasa_top[KasaW-1:0];
    assign w_yolcu_art   = r_yolcu + 6'd1;
    assign w_zaman_doldu = (r_zaman == ZW'(ZAMAN_ASIMI - 1));

    // Outputs are computed for the state being entered, so a transition and
    // its pulse appear together in the following cycle.
    always_comb begin
        w_durum_d     = r_durum;
        w_ucret_d     = r_ucret;
        w_odenen_d    = r_odenen;
        w_zaman_d     = r_zaman;
        w_para_ustu_d = '0;
        w_odendi_d    = 1'b0;
        w_iade_d      = 1'b0;
        w_yolcu_d     = r_yolcu;
        w_dolu_d      = r_dolu;
        w_kasa_d      = r_kasa;

        unique case (r_durum)
            StBekle: begin
                if (i_ucret_gecerli && !r_dolu) begin
                    w_ucret_d  = i_ucret;
                    w_odenen_d = '0;
                    w_zaman_d  = '0;
                    if (i_ucret == 8'd0) begin
                        w_durum_d  = StOnay;
                        w_odendi_d = 1'b1;
                        w_yolcu_d  = w_yolcu_art;
                        w_dolu_d   = r_dolu | (w_yolcu_art == 6'(MAKS_YOLCU));
                    end else begin
                        w_durum_d = StTahsilat;
                    end
                end
            end
            StTahsilat: begin
                w_odenen_d = w_odenen_n;
                if (i_para_gecerli) begin
                    w_zaman_d = '0;
                end
                if (i_iptal) begin
                    w_durum_d     = StIade;
                    w_iade_d      = 1'b1;
                    w_para_ustu_d = w_odenen_n;
                end else if (w_odenen_n >= {1'b0, r_ucret}) begin
                    w_durum_d     = StOnay;
                    w_odendi_d    = 1'b1;
                    w_para_ustu_d = w_odenen_n - {1'b0, r_ucret};
                    w_kasa_d      = w_kasa_doygun;
                    w_yolcu_d     = w_yolcu_art;
                    w_dolu_d      = r_dolu | (w_yolcu_art == 6'(MAKS_YOLCU));
                end else if (!i_para_gecerli && w_zaman_doldu) begin
                    w_durum_d     = StIade;
                    w_iade_d      = 1'b1;
                    w_para_ustu_d = r_odenen;
                end else if (!i_para_gecerli) begin
                    w_zaman_d = r_zaman + 1'b1;
                end
            end
            StOnay, StIade: begin
                w_durum_d  = StBekle;
                w_odenen_d = '0;
            end
            default: begin
                w_durum_d  = StBekle;
                w_odenen_d = '0;
            end
        endcase

        w_hazir_d = (w_durum_d == StBekle) && !w_dolu_d;
    end

    always_ff @(posedge i_saat) begin
        if (!i_reset) begin
            r_durum     <= StBekle;
            r_ucret     <= '0;
            r_odenen    <= '0;
            r_zaman     <= '0;
            r_para_ustu <= '0;
            r_odendi    <= 1'b0;
            r_iade      <= 1'b0;
            r_hazir     <= 1'b0;
            r_yolcu     <= '0;
            r_dolu      <= 1'b0;
            r_kasa      <= '0;
        end else begin
            r_durum     <= w_durum_d;
            r_ucret     <= w_ucret_d;
            r_odenen    <= w_odenen_d;
            r_zaman     <= w_zaman_d;
            r_para_ustu <= w_para_ustu_d;
            r_odendi    <= w_odendi_d;
            r_iade      <= w_iade_d;
            r_hazir     <= w_hazir_d;
            r_yolcu     <= w_yolcu_d;
            r_dolu      <= w_dolu_d;
            r_kasa      <= w_kasa_d;
        end
    end

    assign o_hazir        = r_hazir;
    assign o_odendi       = r_odendi;
    assign o_iade         = r_iade;
    assign o_para_ustu    = r_para_ustu;
    assign o_odenen       = r_odenen;
    assign o_yolcu_sayisi = r_yolcu;
    assign o_ucak_dolu    = r_dolu;
    assign o_kasa         = r_kasa;

endmodule
